// File: rtl/ex_mdu.sv
// ---------------------------------------------------------------------------
// ex_mdu -- multi-cycle multiply/divide unit for the EX stage
//
// Owns the architectural HI/LO registers. MULT/MULTU/DIV/DIVU compute their
// 64-bit result at the accept edge into a pending register, then hold busy
// for a fixed number of cycles before committing it to HI/LO in one step.
// MTHI/MTLO write directly with no latency.
//
// Optional feature macro: MDU_MADD_EN -- when defined, op 7 (MADD) and
// op 8 (MADDU) accumulate the product into {HI,LO}; when undefined they are
// treated as "no operation".
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   start      EX instruction is an MDU op this cycle
//   op         operation code (0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//              5 MTHI, 6 MTLO, 7 MADD, 8 MADDU)
//   a, b       forwarded rs/rt operands
//   flush      EX instruction is being cancelled this cycle
//   busy       an operation is in flight
//   stall_req  combinational stall request to the hazard unit
//   hi, lo     architectural HI/LO registers
// ---------------------------------------------------------------------------
module ex_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CntW      = $clog2(MaxCycles + 1);

    typedef enum logic [3:0] {
        OpNone  = 4'd0,
        OpMult  = 4'd1,
        OpMultu = 4'd2,
        OpDiv   = 4'd3,
        OpDivu  = 4'd4,
        OpMthi  = 4'd5,
        OpMtlo  = 4'd6,
        OpMadd  = 4'd7,
        OpMaddu = 4'd8
    } mdu_op_e;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } mdu_state_e;

    mdu_state_e       state_q;
    logic [CntW-1:0]  count_q;
    logic [63:0]      pending_q;
    logic [63:0]      pending_d;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    logic             opValid;
    logic             isDiv;
    logic             accept;
    logic [63:0]      prodSigned;
    logic [63:0]      prodUnsigned;
    logic [31:0]      aMag;
    logic [31:0]      bMag;
    logic [31:0]      bSafe;
    logic [31:0]      quotMag;
    logic [31:0]      remMag;
    logic [31:0]      quotSigned;
    logic [31:0]      remSigned;
    logic [31:0]      quotUnsigned;
    logic [31:0]      remUnsigned;

    // Decode which op codes this build recognises; anything else is "none".
    always_comb begin
        opValid = 1'b0;
        isDiv   = 1'b0;
        case (op)
            OpMult, OpMultu, OpMthi, OpMtlo: opValid = 1'b1;
            OpDiv, OpDivu: begin
                opValid = 1'b1;
                isDiv   = 1'b1;
            end
`ifdef MDU_MADD_EN
            OpMadd, OpMaddu: opValid = 1'b1;
`endif
            default: opValid = 1'b0;
        endcase
    end

    assign accept    = start & ~flush & opValid & (state_q == StIdle);
    assign busy      = (state_q == StBusy);
    assign stall_req = busy | (start & opValid);
    assign hi        = hi_q;
    assign lo        = lo_q;

    // Result datapath. Signed division works on magnitudes and then fixes
    // signs, which also yields 0x80000000 / -1 = 0x80000000 rem 0 without a
    // special case. A zero divisor is replaced by 1 only to keep the divider
    // X-free; that result is discarded in favour of the current HI/LO.
    always_comb begin
        prodSigned   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prodUnsigned = {32'd0, a} * {32'd0, b};
        bSafe        = (b == 32'd0) ? 32'd1 : b;
        aMag         = a[31] ? (~a + 32'd1) : a;
        bMag         = bSafe[31] ? (~bSafe + 32'd1) : bSafe;
        quotMag      = aMag / bMag;
        remMag       = aMag % bMag;
        quotSigned   = (a[31] ^ bSafe[31]) ? (~quotMag + 32'd1) : quotMag;
        remSigned    = a[31] ? (~remMag + 32'd1) : remMag;
        quotUnsigned = a / bSafe;
        remUnsigned  = a % bSafe;

        pending_d = {hi_q, lo_q};
        case (op)
            OpMult:  pending_d = prodSigned;
            OpMultu: pending_d = prodUnsigned;
            OpDiv:   if (b != 32'd0) pending_d = {remSigned, quotSigned};
            OpDivu:  if (b != 32'd0) pending_d = {remUnsigned, quotUnsigned};
`ifdef MDU_MADD_EN
            OpMadd:  pending_d = {hi_q, lo_q} + prodSigned;
            OpMaddu: pending_d = {hi_q, lo_q} + prodUnsigned;
`endif
            default: pending_d = {hi_q, lo_q};
        endcase
    end

    // Control FSM. Busy lasts exactly N cycles: the counter is loaded with N
    // at accept and HI/LO are committed on the edge where it steps 1 -> 0.
    // Flush is only consulted at accept; an op already in flight has been
    // committed past EX and always completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            pending_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (op == OpMthi) begin
                            hi_q <= a;
                        end else if (op == OpMtlo) begin
                            lo_q <= a;
                        end else begin
                            pending_q <= pending_d;
                            count_q   <= isDiv ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                            state_q   <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    count_q <= count_q - CntW'(1);
                    if (count_q == CntW'(1)) begin
                        hi_q    <= pending_q[63:32];
                        lo_q    <= pending_q[31:0];
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// ---------------------------------------------------------------------------
// tb_ex_mdu -- self-checking bench for ex_mdu
//
// A behavioural model (plain 64-bit arithmetic and a cycle countdown) runs
// alongside the DUT and one compare process checks busy/stall_req/hi/lo on
// every falling edge. Directed scenarios also pin results to hand-computed
// literals. Honours MDU_MADD_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_ex_mdu;

    localparam int MultCycles = 5;
    localparam int DivCycles  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    logic [31:0] mHi;
    logic [31:0] mLo;
    logic [63:0] mRes;
    int          mLeft;

    ex_mdu #(
        .MULT_CYCLES(MultCycles),
        .DIV_CYCLES (DivCycles)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .busy     (busy),
        .stall_req(stall_req),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    // Which op codes the unit must recognise in this build.
    function automatic bit modelValid(input logic [3:0] o);
`ifdef MDU_MADD_EN
        return (o >= 4'd1) && (o <= 4'd8);
`else
        return (o >= 4'd1) && (o <= 4'd6);
`endif
    endfunction

    // Reference model: results from 64-bit integer arithmetic, latency as a
    // plain count of remaining busy cycles.
    always @(posedge clk) begin
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (reset) begin
            mHi = 0; mLo = 0; mRes = 0; mLeft = 0;
        end else if (mLeft > 0) begin
            mLeft = mLeft - 1;
            if (mLeft == 0) begin
                mHi = mRes[63:32];
                mLo = mRes[31:0];
            end
        end else if (start && !flush && modelValid(op)) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            case (op)
                4'd1: begin mRes = 64'(sa * sb); mLeft = MultCycles; end
                4'd2: begin mRes = 64'(a) * 64'(b); mLeft = MultCycles; end
                4'd3: begin
                    if (b == 0) mRes = {mHi, mLo};
                    else begin q = sa / sb; r = sa % sb; mRes = {r[31:0], q[31:0]}; end
                    mLeft = DivCycles;
                end
                4'd4: begin
                    if (b == 0) mRes = {mHi, mLo};
                    else begin
                        q = longint'(64'(a)) / longint'(64'(b));
                        r = longint'(64'(a)) % longint'(64'(b));
                        mRes = {r[31:0], q[31:0]};
                    end
                    mLeft = DivCycles;
                end
                4'd5: mHi = a;
                4'd6: mLo = a;
                4'd7: begin mRes = {mHi, mLo} + 64'(sa * sb); mLeft = MultCycles; end
                4'd8: begin mRes = {mHi, mLo} + 64'(a) * 64'(b); mLeft = MultCycles; end
                default: ;
            endcase
        end
    end

    // Continuous comparison of every output against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checks = checks + 4;
            if (busy !== (mLeft > 0)) begin
                errors++;
                $display("[TB] FAIL model.busy: got %0b expected %0b", busy, (mLeft > 0));
            end
            if (stall_req !== ((mLeft > 0) || (start && modelValid(op)))) begin
                errors++;
                $display("[TB] FAIL model.stall_req: got %0b expected %0b", stall_req,
                         ((mLeft > 0) || (start && modelValid(op))));
            end
            if (hi !== mHi) begin
                errors++;
                $display("[TB] FAIL model.hi: got %h expected %h", hi, mHi);
            end
            if (lo !== mLo) begin
                errors++;
                $display("[TB] FAIL model.lo: got %h expected %h", lo, mLo);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One-cycle start pulse; the unit must be idle so it is accepted.
    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk); #2;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #2;
        start = 1'b0; op = 4'd0;
    endtask

    // Counts busy cycles until the first idle falling edge (bounded).
    task automatic waitIdle(output int n);
        bit done;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL waitIdle: busy still high after %0d cycles", n);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        checkEn = 1'b1;
        checkOutput("reset.hi", hi, 32'h0);
        checkOutput("reset.lo", lo, 32'h0);
        checkOutput("reset.busy", {31'd0, busy}, 32'd0);

        $display("[TB] MULT -2 * 3");
        applyStimulus(4'd1, 32'hFFFF_FFFE, 32'd3);
        waitIdle(n);
        checkOutput("mult.cycles", n, 32'd5);
        checkOutput("mult.hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult.lo", lo, 32'hFFFF_FFFA);

        $display("[TB] MULTU 0xFFFFFFFE * 3");
        applyStimulus(4'd2, 32'hFFFF_FFFE, 32'd3);
        waitIdle(n);
        checkOutput("multu.hi", hi, 32'h0000_0002);
        checkOutput("multu.lo", lo, 32'hFFFF_FFFA);

        $display("[TB] DIV -7 / 2");
        applyStimulus(4'd3, 32'hFFFF_FFF9, 32'd2);
        waitIdle(n);
        checkOutput("div.cycles", n, 32'd10);
        checkOutput("div.lo", lo, 32'hFFFF_FFFD);
        checkOutput("div.hi", hi, 32'hFFFF_FFFF);

        $display("[TB] MTHI/MTLO then DIVU by zero");
        applyStimulus(4'd5, 32'h11, 32'd0);
        waitIdle(n);
        checkOutput("mthi.cycles", n, 32'd0);
        applyStimulus(4'd6, 32'h22, 32'd0);
        waitIdle(n);
        checkOutput("mtlo.lo", lo, 32'h22);
        applyStimulus(4'd4, 32'd7, 32'd0);
        waitIdle(n);
        checkOutput("divu0.cycles", n, 32'd10);
        checkOutput("divu0.hi", hi, 32'h11);
        checkOutput("divu0.lo", lo, 32'h22);

        $display("[TB] DIV overflow case");
        applyStimulus(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        waitIdle(n);
        checkOutput("divovf.lo", lo, 32'h8000_0000);
        checkOutput("divovf.hi", hi, 32'h0);

        $display("[TB] DIVU 100 / 7");
        applyStimulus(4'd4, 32'd100, 32'd7);
        waitIdle(n);
        checkOutput("divu.lo", lo, 32'd14);
        checkOutput("divu.hi", hi, 32'd2);

        $display("[TB] MTLO held during MULT");
        applyStimulus(4'd1, 32'hFFFF_FFFE, 32'd3);
        start = 1'b1; op = 4'd6; a = 32'd5; b = 32'd0;
        waitIdle(n);
        @(posedge clk); #2;
        start = 1'b0; op = 4'd0;
        @(negedge clk);
        checkOutput("hold.lo", lo, 32'd5);
        checkOutput("hold.hi", hi, 32'hFFFF_FFFF);
        checkOutput("hold.busy", {31'd0, busy}, 32'd0);

        $display("[TB] flush with start");
        @(posedge clk); #2;
        start = 1'b1; op = 4'd1; a = 32'd9; b = 32'd9; flush = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; op = 4'd0; flush = 1'b0;
        @(negedge clk);
        checkOutput("flushstart.busy", {31'd0, busy}, 32'd0);
        checkOutput("flushstart.lo", lo, 32'd5);

        $display("[TB] flush during busy");
        applyStimulus(4'd2, 32'd6, 32'd7);
        @(posedge clk); #2 flush = 1'b1;
        @(posedge clk); #2 flush = 1'b0;
        waitIdle(n);
        checkOutput("flushbusy.hi", hi, 32'd0);
        checkOutput("flushbusy.lo", lo, 32'd42);

        $display("[TB] reset during DIV");
        applyStimulus(4'd3, 32'd100, 32'd3);
        @(posedge clk); #2;
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        checkOutput("rstdiv.busy", {31'd0, busy}, 32'd0);
        checkOutput("rstdiv.hi", hi, 32'd0);
        checkOutput("rstdiv.lo", lo, 32'd0);
        repeat (12) @(negedge clk);
        checkOutput("rstdiv.late.lo", lo, 32'd0);

        $display("[TB] MADDU accumulate");
        applyStimulus(4'd5, 32'd0, 32'd0);
        applyStimulus(4'd6, 32'hFFFF_FFFF, 32'd0);
        @(posedge clk); #2;
        start = 1'b1; op = 4'd8; a = 32'd1; b = 32'd1;
        @(negedge clk);
`ifdef MDU_MADD_EN
        checkOutput("maddu.stall", {31'd0, stall_req}, 32'd1);
`else
        checkOutput("maddu.stall", {31'd0, stall_req}, 32'd0);
`endif
        @(posedge clk); #2;
        start = 1'b0; op = 4'd0;
        waitIdle(n);
`ifdef MDU_MADD_EN
        checkOutput("maddu.cycles", n, 32'd5);
        checkOutput("maddu.hi", hi, 32'd1);
        checkOutput("maddu.lo", lo, 32'd0);
`else
        checkOutput("maddu.cycles", n, 32'd0);
        checkOutput("maddu.hi", hi, 32'd0);
        checkOutput("maddu.lo", lo, 32'hFFFF_FFFF);
`endif

        repeat (2) @(negedge clk);
        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
